snake_datapath: RTL

//   Datapath driven by the snake control FSM (ld / update / plot strobes).

---
 rtl/snake_datapath.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/snake_datapath.sv
// Snake game datapath: body shift register, heading latch, growth, self-collision
// detection and the per-update VGA draw-head / erase-tail pixel burst.
module snake_datapath #(
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned INIT_LEN = 4,
    parameter int unsigned START_X  = 80,
    parameter int unsigned START_Y  = 60,
    parameter logic [2:0]  HEAD_COL = 3'b010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld,
    input  logic       update,
    input  logic       plot,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       grow,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       vga_we,
    output logic       game_over,
    output logic [5:0] length
);

    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned CW = 3;
    localparam int unsigned LW = 6;
    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam logic [XW-1:0] X_LAST = XW'(159);
    localparam logic [YW-1:0] Y_LAST = YW'(119);

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    logic [XW-1:0] seg_x_q [MAX_LEN];
    logic [XW-1:0] seg_x_d [MAX_LEN];
    logic [YW-1:0] seg_y_q [MAX_LEN];
    logic [YW-1:0] seg_y_d [MAX_LEN];
    dir_t          dir_q, dir_d;
    logic [LW-1:0] length_q, length_d;
    logic          game_over_q, game_over_d;
    logic          grow_pend_q, grow_pend_d;
    logic          erase_valid_q, erase_valid_d;
    logic [XW-1:0] erase_x_q, erase_x_d;
    logic [YW-1:0] erase_y_q, erase_y_d;
    logic [1:0]    pcnt_q, pcnt_d;

    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic          hit;
    logic [IW-1:0] tail_idx;

    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    assign tail_idx  = IW'(length_q - LW'(1));
    assign game_over = game_over_q;
    assign length    = length_q;

    // Next head cell, wrapping at the screen edges
    always_comb begin
        head_x = seg_x_q[0];
        head_y = seg_y_q[0];
        case (dir_q)
            DIR_UP:    head_y = (seg_y_q[0] == '0) ? Y_LAST : seg_y_q[0] - YW'(1);
            DIR_DOWN:  head_y = (seg_y_q[0] == Y_LAST) ? '0 : seg_y_q[0] + YW'(1);
            DIR_LEFT:  head_x = (seg_x_q[0] == '0) ? X_LAST : seg_x_q[0] - XW'(1);
            DIR_RIGHT: head_x = (seg_x_q[0] == X_LAST) ? '0 : seg_x_q[0] + XW'(1);
            default: ;
        endcase
    end

    // Self-collision: new head against every live segment except the departing tail
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < MAX_LEN - 1; i++) begin
            if ((LW'(i) < length_q - LW'(1)) &&
                (seg_x_q[IW'(i)] == head_x) && (seg_y_q[IW'(i)] == head_y))
                hit = 1'b1;
        end
    end

    // Next-state logic; ld restores the reset state and outranks update
    always_comb begin
        seg_x_d       = seg_x_q;
        seg_y_d       = seg_y_q;
        dir_d         = dir_q;
        length_d      = length_q;
        game_over_d   = game_over_q;
        grow_pend_d   = grow_pend_q | grow;
        erase_valid_d = erase_valid_q;
        erase_x_d     = erase_x_q;
        erase_y_d     = erase_y_q;
        pcnt_d        = plot ? pcnt_q + 2'd1 : 2'd0;

        // Highest-priority key wins; a reversal request is dropped outright
        if (key_up) begin
            if (opposite(dir_q) != DIR_UP) dir_d = DIR_UP;
        end else if (key_down) begin
            if (opposite(dir_q) != DIR_DOWN) dir_d = DIR_DOWN;
        end else if (key_left) begin
            if (opposite(dir_q) != DIR_LEFT) dir_d = DIR_LEFT;
        end else if (key_right) begin
            if (opposite(dir_q) != DIR_RIGHT) dir_d = DIR_RIGHT;
        end

        if (ld) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_d[IW'(i)] = XW'(START_X - i);
                seg_y_d[IW'(i)] = YW'(START_Y);
            end
            dir_d         = DIR_RIGHT;
            length_d      = LW'(INIT_LEN);
            game_over_d   = 1'b0;
            grow_pend_d   = 1'b0;
            erase_valid_d = 1'b0;
            pcnt_d        = 2'd0;
        end else if (update && !game_over_q) begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
                seg_x_d[IW'(i)] = seg_x_q[IW'(i - 1)];
                seg_y_d[IW'(i)] = seg_y_q[IW'(i - 1)];
            end
            seg_x_d[0]  = head_x;
            seg_y_d[0]  = head_y;
            erase_x_d   = seg_x_q[tail_idx];
            erase_y_d   = seg_y_q[tail_idx];
            // A grow pulse arriving with this update is kept for the next one
            grow_pend_d = grow;
            if (grow_pend_q && (length_q < LW'(MAX_LEN))) begin
                length_d      = length_q + LW'(1);
                erase_valid_d = 1'b0;
            end else begin
                erase_valid_d = 1'b1;
            end
            if (hit) game_over_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[IW'(i)] <= XW'(START_X - i);
                seg_y_q[IW'(i)] <= YW'(START_Y);
            end
            dir_q         <= DIR_RIGHT;
            length_q      <= LW'(INIT_LEN);
            game_over_q   <= 1'b0;
            grow_pend_q   <= 1'b0;
            erase_valid_q <= 1'b0;
            erase_x_q     <= '0;
            erase_y_q     <= '0;
            pcnt_q        <= 2'd0;
        end else begin
            seg_x_q       <= seg_x_d;
            seg_y_q       <= seg_y_d;
            dir_q         <= dir_d;
            length_q      <= length_d;
            game_over_q   <= game_over_d;
            grow_pend_q   <= grow_pend_d;
            erase_valid_q <= erase_valid_d;
            erase_x_q     <= erase_x_d;
            erase_y_q     <= erase_y_d;
            pcnt_q        <= pcnt_d;
        end
    end

    // Pixel port follows plot/pcnt directly so the burst costs no extra cycle
    always_comb begin
        x      = '0;
        y      = '0;
        colour = '0;
        vga_we = 1'b0;
        if (rst && plot) begin
            case (pcnt_q)
                2'd0: begin
                    x      = seg_x_q[0];
                    y      = seg_y_q[0];
                    colour = CW'(HEAD_COL);
                    vga_we = 1'b1;
                end
                2'd1: begin
                    x      = erase_x_q;
                    y      = erase_y_q;
                    vga_we = erase_valid_q;
                end
                default: ;
            endcase
        end
    end

endmodule
